sort_arbiter: RTL

Round-robin arbiter that shares one merge-sort engine between NUM_REQ requesters, e.g. several BWT suffix-sorting cores or a BWT core and a key pre-sort stage. It latches the winning requester's key block and sort selector, pulses the engine start, waits for the engine's sorted pulse under a watchdog, captures the sorted block and returns it with a per-requester done or error pulse. It sits between the requesters and the single sort instance; requesters never drive the engine directly.

---
 rtl/sort_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sort_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// sort_arbiter: round-robin front end sharing one merge-sort engine (rev 1.0)
//------------------------------------------------------------------------------
module sort_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int STRING_LEN = 8,
   parameter int WORD_NUM   = 3,
   parameter int TIMEOUT    = 1024
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_REQ-1:0]                         req,
   input  logic [NUM_REQ*STRING_LEN*WORD_NUM*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]                         req_sort_num,
   output logic [NUM_REQ-1:0]                         gnt,
   output logic [NUM_REQ-1:0]                         done,
   output logic [NUM_REQ-1:0]                         err,
   output logic [STRING_LEN*WORD_NUM*8-1:0]           result_data,
   output logic                                       busy,
   output logic                                       eng_start,
   output logic [STRING_LEN*WORD_NUM*8-1:0]           eng_data_in,
   output logic                                       eng_sort_num,
   input  logic                                       eng_sorted,
   input  logic [STRING_LEN*WORD_NUM*8-1:0]           eng_data_out
);

   localparam int BLK_W = STRING_LEN*WORD_NUM*8;
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT+1);

   localparam logic [CNT_W-1:0]   CNT_EXPIRE = CNT_W'(TIMEOUT-1);
   localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ-1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [NUM_REQ-1:0] gnt_nxt, done_nxt, err_nxt;
   logic [BLK_W-1:0]   result_nxt, data_in_nxt;
   logic               busy_nxt, start_nxt, sort_nxt;

   logic [BLK_W-1:0]   req_blk [NUM_REQ];
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   int                 cand;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_blk
      assign req_blk[i] = req_data[i*BLK_W +: BLK_W];
   end

   // Round-robin search beginning one past the previous winner
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!win_found && req[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      cnt_nxt     = cnt;
      gnt_nxt     = gnt;
      done_nxt    = '0;
      err_nxt     = '0;
      start_nxt   = 1'b0;
      data_in_nxt = eng_data_in;
      sort_nxt    = eng_sort_num;
      result_nxt  = result_data;

      case (state)
         S_IDLE: begin
            gnt_nxt = '0;
            if (win_found) begin
               gnt_nxt     = ONE_HOT0 << win_idx;
               data_in_nxt = req_blk[win_idx];
               sort_nxt    = req_sort_num[win_idx];
               last_nxt    = win_idx;
               state_nxt   = S_LOAD;
            end
         end
         S_LOAD: begin
            start_nxt = 1'b1;
            state_nxt = S_START;
         end
         S_START: begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
            // A completion arriving on the expiry cycle still counts as success
            if (eng_sorted) begin
               result_nxt     = eng_data_out;
               done_nxt[last] = 1'b1;
               state_nxt      = S_RELEASE;
            end else if (cnt == CNT_EXPIRE) begin
               err_nxt[last]  = 1'b1;
               state_nxt      = S_RELEASE;
            end
         end
         S_RELEASE: begin
            gnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         last         <= IDX_LAST;
         cnt          <= '0;
         gnt          <= '0;
         done         <= '0;
         err          <= '0;
         busy         <= 1'b0;
         eng_start    <= 1'b0;
         eng_data_in  <= '0;
         eng_sort_num <= 1'b0;
         result_data  <= '0;
      end else begin
         state        <= state_nxt;
         last         <= last_nxt;
         cnt          <= cnt_nxt;
         gnt          <= gnt_nxt;
         done         <= done_nxt;
         err          <= err_nxt;
         busy         <= busy_nxt;
         eng_start    <= start_nxt;
         eng_data_in  <= data_in_nxt;
         eng_sort_num <= sort_nxt;
         result_data  <= result_nxt;
      end
   end

endmodule
`default_nettype wire
